// File: rtl/timer_mm_sequencer_if.sv
// Avalon-MM bus between the sequencer (master) and the interval-timer slave,
// plus the slave's irq line.
interface timer_mm_sequencer_if;
   logic [2:0]  avm_address;
   logic        avm_chipselect;
   logic        avm_write_n;
   logic [15:0] avm_writedata;
   logic [15:0] avm_readdata;
   logic        timer_irq;

   modport master (
      output avm_address, avm_chipselect, avm_write_n, avm_writedata,
      input  avm_readdata, timer_irq
   );

   modport slave (
      input  avm_address, avm_chipselect, avm_write_n, avm_writedata,
      output avm_readdata, timer_irq
   );
endinterface

// File: rtl/timer_mm_sequencer.sv
// Avalon-MM initiator that programs the interval timer, services each timeout and stops it.
// Latency: first control write 3 cycles after start, 7 cycles per serviced tick; no waitrequest, so never stalls.
module timer_mm_sequencer #(
   parameter int READ_LATENCY = 1,
   parameter int TICK_W       = 16
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  i_start,
   input  logic                  i_abort,
   input  logic [31:0]           i_period,
   input  logic                  i_continuous,
   input  logic [TICK_W-1:0]     i_num_ticks,
   output logic                  o_busy,
   output logic                  o_tick,
   output logic                  o_done,
   output logic [TICK_W-1:0]     o_tick_count,
   output logic [31:0]           o_snapshot,
   timer_mm_sequencer_if.master  avm
);

   // The capture states assume the slave registers readdata exactly once.
   if (READ_LATENCY != 1) begin : g_bad_read_latency
      $error("timer_mm_sequencer supports READ_LATENCY == 1 only");
   end

   typedef enum logic [3:0] {
      S_IDLE, S_WR_PL, S_WR_PH, S_WR_CTL, S_WAIT_IRQ, S_WR_STAT, S_WR_SNAP,
      S_RD_SL, S_CAP_SL, S_RD_SH, S_CAP_SH, S_WR_STOP, S_DONE
   } state_t;

   state_t              r_state;
   logic                r_busy, r_tick, r_done, r_abort, r_cont;
   logic [TICK_W-1:0]   r_tick_count, r_num_ticks;
   logic [31:0]         r_snapshot, r_period;
   logic                r_cs, r_wr_n;
   logic [2:0]          r_addr;
   logic [15:0]         r_wdata;

   logic [15:0]         w_ctl;
   logic [TICK_W-1:0]   w_cnt_inc;
   logic                w_abort, w_last;

   // Control register: bit3 STOP, bit2 START, bit1 CONT, bit0 ITO.
   assign w_ctl     = {13'd0, 1'b1, r_cont, 1'b1};
   assign w_cnt_inc = r_tick_count + {{(TICK_W-1){1'b0}}, 1'b1};
   assign w_abort   = r_abort | i_abort;
   assign w_last    = (r_num_ticks != '0) && (w_cnt_inc == r_num_ticks);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state      <= S_IDLE;
         r_busy       <= 1'b0;
         r_tick       <= 1'b0;
         r_done       <= 1'b0;
         r_abort      <= 1'b0;
         r_cont       <= 1'b0;
         r_tick_count <= '0;
         r_num_ticks  <= '0;
         r_snapshot   <= '0;
         r_period     <= '0;
         r_cs         <= 1'b0;
         r_wr_n       <= 1'b1;
         r_addr       <= 3'd0;
         r_wdata      <= 16'd0;
      end else begin
         r_cs    <= 1'b0;
         r_wr_n  <= 1'b1;
         r_addr  <= 3'd0;
         r_wdata <= 16'd0;
         r_tick  <= 1'b0;
         r_done  <= 1'b0;
         if (i_abort && r_state != S_IDLE) r_abort <= 1'b1;

         case (r_state)
            S_IDLE: if (i_start) begin
               r_period     <= i_period;
               r_cont       <= i_continuous;
               r_num_ticks  <= i_num_ticks;
               r_tick_count <= '0;
               r_abort      <= 1'b0;
               r_busy       <= 1'b1;
               r_cs         <= 1'b1;
               r_wr_n       <= 1'b0;
               r_addr       <= 3'd2;
               r_wdata      <= i_period[15:0];
               r_state      <= S_WR_PL;
            end
            S_WR_PL: begin
               r_cs    <= 1'b1;
               r_wr_n  <= 1'b0;
               r_addr  <= 3'd3;
               r_wdata <= r_period[31:16];
               r_state <= S_WR_PH;
            end
            S_WR_PH: begin
               r_cs    <= 1'b1;
               r_wr_n  <= 1'b0;
               r_addr  <= 3'd1;
               r_wdata <= w_ctl;
               r_state <= S_WR_CTL;
            end
            S_WR_CTL: r_state <= S_WAIT_IRQ;
            S_WAIT_IRQ: begin
               // A pending timeout is always serviced before an abort is honoured.
               if (avm.timer_irq) begin
                  r_cs    <= 1'b1;
                  r_wr_n  <= 1'b0;
                  r_addr  <= 3'd0;
                  r_state <= S_WR_STAT;
               end else if (w_abort) begin
                  r_cs    <= 1'b1;
                  r_wr_n  <= 1'b0;
                  r_addr  <= 3'd1;
                  r_wdata <= 16'h0008;
                  r_state <= S_WR_STOP;
               end
            end
            S_WR_STAT: begin
               r_cs    <= 1'b1;
               r_wr_n  <= 1'b0;
               r_addr  <= 3'd4;
               r_state <= S_WR_SNAP;
            end
            S_WR_SNAP: begin
               r_cs    <= 1'b1;
               r_addr  <= 3'd4;
               r_state <= S_RD_SL;
            end
            S_RD_SL:  r_state <= S_CAP_SL;
            S_CAP_SL: begin
               r_snapshot[15:0] <= avm.avm_readdata;
               r_cs             <= 1'b1;
               r_addr           <= 3'd5;
               r_state          <= S_RD_SH;
            end
            S_RD_SH:  r_state <= S_CAP_SH;
            S_CAP_SH: begin
               r_snapshot[31:16] <= avm.avm_readdata;
               r_tick_count      <= w_cnt_inc;
               r_tick            <= 1'b1;
               if (w_last || w_abort) begin
                  r_cs    <= 1'b1;
                  r_wr_n  <= 1'b0;
                  r_addr  <= 3'd1;
                  r_wdata <= 16'h0008;
                  r_state <= S_WR_STOP;
               end else if (!r_cont) begin
                  r_cs    <= 1'b1;
                  r_wr_n  <= 1'b0;
                  r_addr  <= 3'd1;
                  r_wdata <= w_ctl;
                  r_state <= S_WR_CTL;
               end else begin
                  r_state <= S_WAIT_IRQ;
               end
            end
            S_WR_STOP: begin
               r_done  <= 1'b1;
               r_busy  <= 1'b0;
               r_state <= S_DONE;
            end
            S_DONE:   r_state <= S_IDLE;
            default:  r_state <= S_IDLE;
         endcase
      end
   end

   assign o_busy             = r_busy;
   assign o_tick             = r_tick;
   assign o_done             = r_done;
   assign o_tick_count       = r_tick_count;
   assign o_snapshot         = r_snapshot;
   assign avm.avm_address    = r_addr;
   assign avm.avm_chipselect = r_cs;
   assign avm.avm_write_n    = r_wr_n;
   assign avm.avm_writedata  = r_wdata;

endmodule

// File: tb/tb_timer_mm_sequencer.sv
// Randomized bench: a behavioural timer slave plus a transaction-level model of the
// expected write sequence, tick pulses, snapshots and tick counts.
module tb_timer_mm_sequencer;
   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        i_start = 1'b0, i_abort = 1'b0, i_continuous = 1'b0;
   logic [31:0] i_period = '0;
   logic [15:0] i_num_ticks = '0;
   logic        o_busy, o_tick, o_done;
   logic [15:0] o_tick_count;
   logic [31:0] o_snapshot;

   timer_mm_sequencer_if bus();

   timer_mm_sequencer #(.READ_LATENCY(1), .TICK_W(16)) dut (
      .clk(clk), .reset_n(reset_n),
      .i_start(i_start), .i_abort(i_abort), .i_period(i_period),
      .i_continuous(i_continuous), .i_num_ticks(i_num_ticks),
      .o_busy(o_busy), .o_tick(o_tick), .o_done(o_done),
      .o_tick_count(o_tick_count), .o_snapshot(o_snapshot),
      .avm(bus.master)
   );

   always #5 clk = ~clk;

   // Timer slave: TO flag, ITO enable, snapshot latch, registered readdata.
   logic        to_set = 1'b0, to_flag = 1'b0, ito = 1'b0;
   logic [31:0] cur_count = '0, snap_reg = '0;
   logic [15:0] rdata = '0;
   assign bus.timer_irq    = to_flag & ito;
   assign bus.avm_readdata = rdata;

   always @(posedge clk) begin
      if (to_set) to_flag <= 1'b1;
      if (bus.avm_chipselect && !bus.avm_write_n) begin
         case (bus.avm_address)
            3'd0: to_flag <= 1'b0;
            3'd1: ito <= bus.avm_writedata[0];
            3'd4: snap_reg <= cur_count;
            default: ;
         endcase
      end
      if (bus.avm_chipselect && bus.avm_write_n)
         rdata <= (bus.avm_address == 3'd5) ? snap_reg[31:16] : snap_reg[15:0];
   end

   // Monitor, sampled shortly after each rising edge.
   int          cyc = 0, tick_seen = 0, done_seen = 0;
   logic [18:0] wr_q[$];
   int          wr_cyc_q[$];
   always @(posedge clk) begin
      #2;
      cyc++;
      if (bus.avm_chipselect && !bus.avm_write_n) begin
         wr_q.push_back({bus.avm_address, bus.avm_writedata});
         wr_cyc_q.push_back(cyc);
      end
      if (o_tick) tick_seen++;
      if (o_done) done_seen++;
   end

   int n_cmp = 0, n_bad = 0;
   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, exp);
      end
   endtask

   // Expected writes from the command-level rules.
   logic [18:0] exp_q[$];
   task automatic build_exp(input logic [31:0] per, input logic cont, input int ticks,
                            input bit stop_in_wait);
      logic [15:0] ctl;
      ctl = cont ? 16'h0007 : 16'h0005;
      exp_q.delete();
      exp_q.push_back({3'd2, per[15:0]});
      exp_q.push_back({3'd3, per[31:16]});
      exp_q.push_back({3'd1, ctl});
      for (int i = 0; i < ticks; i++) begin
         exp_q.push_back({3'd0, 16'h0000});
         exp_q.push_back({3'd4, 16'h0000});
         if (i == ticks - 1 && !stop_in_wait) exp_q.push_back({3'd1, 16'h0008});
         else if (!cont)                      exp_q.push_back({3'd1, ctl});
      end
      if (stop_in_wait) exp_q.push_back({3'd1, 16'h0008});
   endtask

   task automatic cmp_writes(input string tag, input int base);
      chk({tag, "_nwr"}, 64'(wr_q.size() - base), 64'(exp_q.size()));
      for (int k = 0; k < exp_q.size() && base + k < wr_q.size(); k++)
         chk($sformatf("%s_wr%0d", tag, k), 64'(wr_q[base+k]), 64'(exp_q[k]));
   endtask

   task automatic wait_tick(input string tag, input int target);
      for (int k = 0; k < 40 && tick_seen < target; k++) @(negedge clk);
      chk({tag, "_tick"}, 64'(tick_seen), 64'(target));
   endtask

   logic [31:0] snap_tab[3] = '{32'h0001_0000, 32'h0000_1000, 32'h0000_0010};

   // mode 0: stop on count, 1: abort in WAIT_IRQ, 2: abort during RD_SL of last tick,
   // 3: abort with irq in the same cycle on last tick, 4: start while busy.
   task automatic run(input string tag, input logic [31:0] per, input logic cont,
                      input logic [15:0] n, input int nfire, input int mode, input bit use_tab);
      int base, t0, d0, s_cyc, a_cyc;
      bit found;
      base = wr_q.size(); t0 = tick_seen; d0 = done_seen; a_cyc = 0;
      @(negedge clk);
      i_period = per; i_continuous = cont; i_num_ticks = n; i_start = 1'b1; s_cyc = cyc;
      @(negedge clk);
      i_start = 1'b0; i_period = $urandom; i_continuous = ~cont; i_num_ticks = 16'($urandom);
      chk({tag, "_busy"}, 64'(o_busy), 64'd1);
      repeat (4) @(negedge clk);
      chk({tag, "_nprog"}, 64'(wr_q.size() - base >= 3), 64'd1);
      if (wr_q.size() - base >= 3) begin
         chk({tag, "_lat_pl"},  64'(wr_cyc_q[base]   - s_cyc), 64'd1);
         chk({tag, "_lat_ctl"}, 64'(wr_cyc_q[base+2] - s_cyc), 64'd3);
      end
      for (int i = 0; i < nfire; i++) begin
         repeat ($urandom_range(0, 6)) @(negedge clk);
         cur_count = use_tab ? snap_tab[i % 3] : $urandom;
         if (mode == 4 && i == 0) begin
            i_period = 32'hDEAD_BEEF; i_start = 1'b1;
            @(negedge clk);
            i_start = 1'b0;
         end
         to_set = 1'b1;
         @(negedge clk);
         to_set = 1'b0;
         if (mode == 3 && i == nfire - 1) begin
            i_abort = 1'b1;
            @(negedge clk);
            i_abort = 1'b0;
         end
         if (mode == 2 && i == nfire - 1) begin
            found = 1'b0;
            for (int k = 0; k < 20 && !found; k++) begin
               if (bus.avm_chipselect && bus.avm_write_n && bus.avm_address == 3'd4) found = 1'b1;
               else @(negedge clk);
            end
            chk({tag, "_rdsl"}, 64'(found), 64'd1);
            i_abort = 1'b1;
            @(negedge clk);
            i_abort = 1'b0;
         end
         wait_tick(tag, t0 + i + 1);
         chk($sformatf("%s_snap%0d", tag, i), 64'(o_snapshot), 64'(cur_count));
         chk($sformatf("%s_cnt%0d", tag, i), 64'(o_tick_count), 64'(16'(i + 1)));
      end
      if (mode == 1) begin
         repeat (3) @(negedge clk);
         a_cyc = cyc; i_abort = 1'b1;
         @(negedge clk);
         i_abort = 1'b0;
      end
      for (int k = 0; k < 30 && done_seen == d0; k++) @(negedge clk);
      repeat (3) @(negedge clk);
      chk({tag, "_done"}, 64'(done_seen - d0), 64'd1);
      chk({tag, "_ticks"}, 64'(tick_seen - t0), 64'(nfire));
      chk({tag, "_idle"}, 64'(o_busy), 64'd0);
      if (mode == 1 && wr_cyc_q.size() > base)
         chk({tag, "_abort_lat"}, 64'(wr_cyc_q[wr_cyc_q.size()-1] - a_cyc), 64'd1);
      build_exp(per, cont, nfire, mode == 1);
      cmp_writes(tag, base);
   endtask

   initial begin
      int b2, t0, nr;
      repeat (3) @(negedge clk);
      chk("rst_busy", 64'(o_busy), 64'd0);
      chk("rst_tick", 64'(o_tick), 64'd0);
      chk("rst_done", 64'(o_done), 64'd0);
      chk("rst_cnt",  64'(o_tick_count), 64'd0);
      chk("rst_snap", 64'(o_snapshot), 64'd0);
      chk("rst_bus",  64'({bus.avm_chipselect, bus.avm_write_n, bus.avm_address, bus.avm_writedata}),
          64'({1'b0, 1'b1, 3'd0, 16'd0}));
      reset_n = 1'b1;
      repeat (2) @(negedge clk);

      run("prog",    32'h0001_86A0, 1'b1, 16'd3, 3, 0, 1'b1);
      run("oneshot", $urandom,      1'b0, 16'd2, 2, 0, 1'b0);
      run("abwait",  $urandom,      1'b1, 16'd0, 2, 1, 1'b0);
      run("abrd",    $urandom,      1'b1, 16'd0, 2, 2, 1'b0);
      run("abirq",   $urandom,      1'b1, 16'd0, 1, 3, 1'b0);
      run("busy",    $urandom,      1'b0, 16'd3, 3, 4, 1'b0);

      // Reset while waiting for irq.
      t0 = tick_seen;
      @(negedge clk);
      i_period = $urandom; i_continuous = 1'b1; i_num_ticks = 16'd0; i_start = 1'b1;
      @(negedge clk);
      i_start = 1'b0;
      repeat (4) @(negedge clk);
      cur_count = $urandom; to_set = 1'b1;
      @(negedge clk);
      to_set = 1'b0;
      wait_tick("mrst", t0 + 1);
      repeat (3) @(negedge clk);
      reset_n = 1'b0;
      #1;
      chk("mrst_busy", 64'(o_busy), 64'd0);
      chk("mrst_cnt",  64'(o_tick_count), 64'd0);
      chk("mrst_snap", 64'(o_snapshot), 64'd0);
      chk("mrst_bus",  64'({bus.avm_chipselect, bus.avm_write_n, bus.avm_address}), 64'({1'b0, 1'b1, 3'd0}));
      @(negedge clk);
      reset_n = 1'b1;
      b2 = wr_q.size();
      repeat (10) @(negedge clk);
      chk("mrst_nowr", 64'(wr_q.size() - b2), 64'd0);
      chk("mrst_idle", 64'(o_busy), 64'd0);

      for (int r = 0; r < 6; r++) begin
         nr = $urandom_range(1, 4);
         run($sformatf("rnd%0d", r), $urandom, 1'($urandom_range(0, 1)), 16'(nr), nr, 0, 1'b0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
